// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;
  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/full_sub.sv
// One-bit full subtractor (a - b - bin) built from two half-subtractor cells.
module full_sub (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bo
);
  logic d1, bo1, bo2;

  half_sub u_hs0 (.a(a),  .b(b),   .d(d1), .bo(bo1));
  half_sub u_hs1 (.a(d1), .b(bin), .d(d),  .bo(bo2));

  assign bo = bo1 | bo2;
endmodule

module half_sub (
  input  logic a,
  input  logic b,
  output logic d,
  output logic bo
);
  assign d  = a ^ b;
  assign bo = ~a & b;
endmodule

// File: rtl/serial_sub.sv
// Bit-serial WIDTH-bit subtractor D = A - B, LSB first, one bit per clock.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout
);
  localparam int CW = $clog2(WIDTH + 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, r_sr, r_nxt;
  logic [CW-1:0]    cnt;
  logic             br, d_bit, bo_bit;
  logic             accept, last;

  full_sub u_fs (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .bin(br),
    .d  (d_bit),
    .bo (bo_bit)
  );

  assign accept = start && (state == IDLE || state == DONE);
  assign last   = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
  // Shifting through a concatenation keeps WIDTH=1 legal and reads every bit.
  assign r_nxt  = WIDTH'({d_bit, r_sr} >> 1);
  assign busy   = (state == SHIFT);
  assign done   = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last) state_nxt = DONE;
      DONE:    state_nxt = start ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      r_sr  <= '0;
      cnt   <= '0;
      br    <= 1'b0;
      D     <= '0;
      Bout  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_sr <= A;
        b_sr <= B;
        r_sr <= '0;
        br   <= 1'b0;
        cnt  <= '0;
      end else if (state == SHIFT) begin
        a_sr <= a_sr >> 1;
        b_sr <= b_sr >> 1;
        r_sr <= r_nxt;
        br   <= bo_bit;
        cnt  <= cnt + CW'(1);
        // Outputs only move on the final bit so they hold through SHIFT.
        if (last) begin
          D    <= r_nxt;
          Bout <= bo_bit;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub at WIDTH 8, 4 and 1.
module tb_serial_sub;
  typedef struct {
    logic [7:0] d;
    logic       bo;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  logic rst_n;
  logic       s8, busy8, done8, bo8;
  logic [7:0] a8, b8, d8;
  logic       s4, busy4, done4, bo4;
  logic [3:0] a4, b4, d4;
  logic       s1, busy1, done1, bo1;
  logic [0:0] a1, b1, d1;

  exp_t q8[$], q4[$], q1[$];

  serial_sub #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(s8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .D(d8), .Bout(bo8));
  serial_sub #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(s4), .A(a4), .B(b4),
    .busy(busy4), .done(done4), .D(d4), .Bout(bo4));
  serial_sub #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(s1), .A(a1), .B(b1),
    .busy(busy1), .done(done1), .D(d1), .Bout(bo1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: pop the oldest expectation on every done pulse.
  logic [7:0] d8_prev = '0;
  logic       bo8_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (done8) begin
      chk("overlap8", 32'(busy8), 0);
      chk("done8_expected", 32'(q8.size() != 0), 1);
      if (q8.size() != 0) begin
        e = q8.pop_front();
        chk("d8", 32'(d8), 32'(e.d));
        chk("bout8", 32'(bo8), 32'(e.bo));
        chk("lat8", cyc, e.cyc);
      end
    end else if (busy8) begin
      chk("hold_d8", 32'(d8), 32'(d8_prev));
      chk("hold_bout8", 32'(bo8), 32'(bo8_prev));
    end
    d8_prev  <= d8;
    bo8_prev <= bo8;
  end

  always @(negedge clk) begin
    exp_t e;
    if (done4) begin
      chk("overlap4", 32'(busy4), 0);
      chk("done4_expected", 32'(q4.size() != 0), 1);
      if (q4.size() != 0) begin
        e = q4.pop_front();
        chk("d4", 32'(d4), 32'(e.d[3:0]));
        chk("bout4", 32'(bo4), 32'(e.bo));
        chk("lat4", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (done1) begin
      chk("overlap1", 32'(busy1), 0);
      chk("done1_expected", 32'(q1.size() != 0), 1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        chk("d1", 32'(d1), 32'(e.d[0]));
        chk("bout1", 32'(bo1), 32'(e.bo));
        chk("lat1", cyc, e.cyc);
      end
    end
  end

  // Called at a negedge in IDLE; returns at a negedge with the DUT back in IDLE.
  task automatic op8(input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] ed, input logic ebo, output int nbusy);
    s8 = 1'b1; a8 = a; b8 = b;
    q8.push_back('{ed, ebo, cyc + 1 + 8});
    nbusy = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) s8 = 1'b0;
      if (busy8) nbusy++;
    end
  endtask

  task automatic op1(input logic a, input logic b, input logic ed, input logic ebo);
    s1 = 1'b1; a1 = a; b1 = b;
    q1.push_back('{8'(ed), ebo, cyc + 1 + 1});
    @(negedge clk);
    s1 = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int nb;
    int base;
    rst_n = 1'b0;
    s8 = 0; a8 = '0; b8 = '0;
    s4 = 0; a4 = '0; b4 = '0;
    s1 = 0; a1 = '0; b1 = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy8", 32'(busy8), 0);
    chk("rst_done8", 32'(done8), 0);
    chk("rst_d8", 32'(d8), 0);
    chk("rst_bout8", 32'(bo8), 0);
    chk("rst_busy4", 32'(busy4), 0);
    rst_n = 1'b1;
    @(negedge clk);

    op8(8'h05, 8'h03, 8'h02, 1'b0, nb);
    chk("busy_cycles8", nb, 8);
    op8(8'h03, 8'h05, 8'hFE, 1'b1, nb);
    op8(8'h00, 8'hFF, 8'h01, 1'b1, nb);
    op8(8'hA5, 8'hA5, 8'h00, 1'b0, nb);

    // start pulsed mid-SHIFT with other operands must be ignored
    s8 = 1'b1; a8 = 8'h40; b8 = 8'h01;
    q8.push_back('{8'h3F, 1'b0, cyc + 1 + 8});
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) s8 = 1'b0;
      if (k == 3) begin s8 = 1'b1; a8 = 8'h77; b8 = 8'h11; end
      if (k == 4) s8 = 1'b0;
    end

    // start held across DONE: back-to-back second operation
    s8 = 1'b1; a8 = 8'h3C; b8 = 8'h0F;
    base = cyc + 1;
    q8.push_back('{8'h2D, 1'b0, base + 8});
    q8.push_back('{8'h0F, 1'b0, base + 9 + 8});
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      if (k == 1) begin a8 = 8'h10; b8 = 8'h01; end
      if (k == 10) s8 = 1'b0;
    end

    // reset during SHIFT: no done, outputs cleared
    s8 = 1'b1; a8 = 8'hC8; b8 = 8'h0A;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) s8 = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy8", 32'(busy8), 0);
    chk("abort_done8", 32'(done8), 0);
    chk("abort_d8", 32'(d8), 0);
    chk("abort_bout8", 32'(bo8), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    op8(8'h81, 8'h02, 8'h7F, 1'b0, nb);

    // WIDTH=4 exhaustive, issued back-to-back at full throughput
    s4 = 1'b1;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        a4 = 4'(a); b4 = 4'(b);
        q4.push_back('{8'((a - b) & 15), a < b, cyc + 1 + 4});
        repeat (5) @(negedge clk);
      end
    end
    s4 = 1'b0;
    repeat (3) @(negedge clk);

    op1(1'b1, 1'b1, 1'b0, 1'b0);
    op1(1'b0, 1'b1, 1'b1, 1'b1);
    op1(1'b1, 1'b0, 1'b1, 1'b0);

    repeat (5) @(negedge clk);
    chk("left8", q8.size(), 0);
    chk("left4", q4.size(), 0);
    chk("left1", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
